// File: rtl/id_tracker.sv
// id_tracker: tracks outstanding transactions per ID in a small associative table.
// Each entry holds an ID and a count; an entry with count 0 is free.
module id_tracker #(
    parameter int ID_WIDTH = 0,
    parameter int CAPACITY = 0,
    parameter int MAX_TXNS = 1,
    localparam int CNT_WIDTH = $clog2(MAX_TXNS + 1),
    // Clamped width so an unconfigured instance still elaborates; the check below flags it.
    localparam int IDW = (ID_WIDTH >= 1) ? ID_WIDTH : 1
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic [IDW-1:0]       issue_id_i,
    input  logic                 issue_req_i,
    output logic                 issue_gnt_o,
    input  logic [IDW-1:0]       retire_id_i,
    input  logic                 retire_req_i,
    output logic                 retire_gnt_o,
    output logic                 retire_err_o,
    input  logic [IDW-1:0]       query_id_i,
    output logic [CNT_WIDTH-1:0] query_cnt_o,
    output logic                 empty_o,
    output logic                 full_o
);

    localparam int NUM = (CAPACITY >= 1) ? CAPACITY : 1;
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = CNT_WIDTH'(MAX_TXNS);

    logic [IDW-1:0]       ent_id  [NUM];
    logic [CNT_WIDTH-1:0] ent_cnt [NUM];

    logic [NUM-1:0]       used;
    logic [NUM-1:0]       issue_match;
    logic [NUM-1:0]       retire_match;
    logic [NUM-1:0]       alloc_sel;
    logic [NUM-1:0]       inc;
    logic [NUM-1:0]       dec;
    logic                 issue_hit;
    logic                 retire_hit;
    logic                 alloc_found;
    logic [CNT_WIDTH-1:0] issue_cnt;

    // Parameter sanity: every dimension must be at least one.
    always_comb begin
        assert (ID_WIDTH >= 1 && CAPACITY >= 1 && MAX_TXNS >= 1)
            else $error("id_tracker: ID_WIDTH, CAPACITY and MAX_TXNS must all be >= 1");
    end

    // Lookup of issue/retire/query IDs against registered table state only.
    always_comb begin
        used         = '0;
        issue_match  = '0;
        retire_match = '0;
        alloc_sel    = '0;
        alloc_found  = 1'b0;
        issue_cnt    = '0;
        query_cnt_o  = '0;
        for (int i = 0; i < NUM; i++) begin
            used[i]         = (ent_cnt[i] != '0);
            issue_match[i]  = used[i] && (ent_id[i] == issue_id_i);
            retire_match[i] = used[i] && (ent_id[i] == retire_id_i);
            if (issue_match[i]) begin
                issue_cnt = issue_cnt | ent_cnt[i];
            end
            if (used[i] && (ent_id[i] == query_id_i)) begin
                query_cnt_o = query_cnt_o | ent_cnt[i];
            end
            if (!used[i] && !alloc_found) begin
                alloc_sel[i] = 1'b1;
                alloc_found  = 1'b1;
            end
        end
        issue_hit  = |issue_match;
        retire_hit = |retire_match;
    end

    // Handshake outputs and per-entry increment/decrement strobes.
    always_comb begin
        empty_o      = ~|used;
        full_o       = &used;
        issue_gnt_o  = issue_req_i && (issue_hit ? (issue_cnt < CNT_MAX) : !full_o);
        retire_gnt_o = retire_req_i;
        retire_err_o = retire_req_i && !retire_hit;
        for (int i = 0; i < NUM; i++) begin
            inc[i] = issue_gnt_o && (issue_hit ? issue_match[i] : alloc_sel[i]);
            dec[i] = retire_req_i && retire_match[i];
        end
    end

    // Table update; an entry hit by both an issue and a retire keeps its count.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            for (int i = 0; i < NUM; i++) begin
                ent_id[i]  <= '0;
                ent_cnt[i] <= '0;
            end
        end else begin
            for (int i = 0; i < NUM; i++) begin
                if (inc[i] && !dec[i]) begin
                    ent_cnt[i] <= ent_cnt[i] + CNT_WIDTH'(1);
                end else if (dec[i] && !inc[i]) begin
                    ent_cnt[i] <= ent_cnt[i] - CNT_WIDTH'(1);
                end
                if (inc[i] && !issue_hit) begin
                    ent_id[i] <= issue_id_i;
                end
            end
        end
    end

endmodule

// File: tb/tb_id_tracker.sv
// Directed bench for id_tracker with ID_WIDTH=4, CAPACITY=2, MAX_TXNS=3.
module tb_id_tracker;

    logic       clk_i = 1'b0;
    logic       rst_ni;
    logic [3:0] issue_id_i;
    logic       issue_req_i;
    logic       issue_gnt_o;
    logic [3:0] retire_id_i;
    logic       retire_req_i;
    logic       retire_gnt_o;
    logic       retire_err_o;
    logic [3:0] query_id_i;
    logic [1:0] query_cnt_o;
    logic       empty_o;
    logic       full_o;

    int errors = 0;
    int checks = 0;

    id_tracker #(.ID_WIDTH(4), .CAPACITY(2), .MAX_TXNS(3)) dut (
        .clk_i        (clk_i),
        .rst_ni       (rst_ni),
        .issue_id_i   (issue_id_i),
        .issue_req_i  (issue_req_i),
        .issue_gnt_o  (issue_gnt_o),
        .retire_id_i  (retire_id_i),
        .retire_req_i (retire_req_i),
        .retire_gnt_o (retire_gnt_o),
        .retire_err_o (retire_err_o),
        .query_id_i   (query_id_i),
        .query_cnt_o  (query_cnt_o),
        .empty_o      (empty_o),
        .full_o       (full_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp)
            else begin
                errors++;
                $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
            end
    endtask

    task automatic drive(input logic ireq, input logic [3:0] iid,
                         input logic rreq, input logic [3:0] rid, input logic [3:0] qid);
        issue_req_i  = ireq;
        issue_id_i   = iid;
        retire_req_i = rreq;
        retire_id_i  = rid;
        query_id_i   = qid;
        #1;
    endtask

    task automatic step();
        @(posedge clk_i);
        #1;
    endtask

    initial begin
        rst_ni = 1'b0;
        // reset state, with requests active
        drive(1'b1, 4'd3, 1'b1, 4'd3, 4'd3);
        #1;
        chk("rst_empty", 32'(empty_o), 32'd1);
        chk("rst_full", 32'(full_o), 32'd0);
        chk("rst_query", 32'(query_cnt_o), 32'd0);
        chk("rst_issue_gnt", 32'(issue_gnt_o), 32'd1);
        chk("rst_retire_err", 32'(retire_err_o), 32'd1);
        drive(1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
        step();
        rst_ni = 1'b1;

        // ID 5 issued four times, MAX_TXNS=3
        for (int k = 0; k < 4; k++) begin
            drive(1'b1, 4'd5, 1'b0, 4'd0, 4'd5);
            chk("max_issue_gnt", 32'(issue_gnt_o), (k < 3) ? 32'd1 : 32'd0);
            step();
        end
        drive(1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
        chk("max_query5", 32'(query_cnt_o), 32'd3);
        chk("max_empty", 32'(empty_o), 32'd0);
        chk("max_full", 32'(full_o), 32'd0);

        // unknown ID retired while table busy: error, no change
        drive(1'b0, 4'd0, 1'b1, 4'd6, 4'd5);
        chk("miss_err", 32'(retire_err_o), 32'd1);
        step();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
        chk("miss_query5", 32'(query_cnt_o), 32'd3);

        // drain ID 5
        for (int k = 0; k < 3; k++) begin
            drive(1'b0, 4'd0, 1'b1, 4'd5, 4'd5);
            chk("drain_gnt", 32'(retire_gnt_o), 32'd1);
            chk("drain_err", 32'(retire_err_o), 32'd0);
            step();
            drive(1'b0, 4'd0, 1'b0, 4'd0, 4'd5);
            chk("drain_query5", 32'(query_cnt_o), 32'(2 - k));
        end
        chk("drain_empty", 32'(empty_o), 32'd1);

        // fill table with IDs 1 and 2
        drive(1'b1, 4'd1, 1'b0, 4'd0, 4'd1);
        step();
        drive(1'b1, 4'd2, 1'b0, 4'd0, 4'd2);
        chk("fill_gnt2", 32'(issue_gnt_o), 32'd1);
        step();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 4'd2);
        chk("fill_full", 32'(full_o), 32'd1);
        chk("fill_query2", 32'(query_cnt_o), 32'd1);

        // new ID 3 while retiring ID 1: freed slot not usable this cycle
        drive(1'b1, 4'd3, 1'b1, 4'd1, 4'd3);
        chk("full_issue_gnt", 32'(issue_gnt_o), 32'd0);
        chk("full_retire_err", 32'(retire_err_o), 32'd0);
        step();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        chk("freed_full", 32'(full_o), 32'd0);
        chk("freed_query3", 32'(query_cnt_o), 32'd0);
        drive(1'b1, 4'd3, 1'b0, 4'd0, 4'd3);
        chk("reuse_gnt", 32'(issue_gnt_o), 32'd1);
        step();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 4'd3);
        chk("reuse_query3", 32'(query_cnt_o), 32'd1);
        chk("reuse_full", 32'(full_o), 32'd1);
        drive(1'b0, 4'd0, 1'b1, 4'd2, 4'd0);
        step();
        drive(1'b0, 4'd0, 1'b1, 4'd3, 4'd0);
        step();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 4'd0);
        chk("clean_empty", 32'(empty_o), 32'd1);

        // retire on empty table
        drive(1'b0, 4'd0, 1'b1, 4'd7, 4'd7);
        chk("empty_ret_gnt", 32'(retire_gnt_o), 32'd1);
        chk("empty_ret_err", 32'(retire_err_o), 32'd1);
        step();
        drive(1'b0, 4'd0, 1'b0, 4'd7, 4'd7);
        chk("empty_ret_empty", 32'(empty_o), 32'd1);
        chk("no_req_err", 32'(retire_err_o), 32'd0);

        // ID 4 at cnt=1: simultaneous issue and retire
        drive(1'b1, 4'd4, 1'b0, 4'd0, 4'd4);
        step();
        drive(1'b1, 4'd4, 1'b1, 4'd4, 4'd4);
        chk("same1_issue_gnt", 32'(issue_gnt_o), 32'd1);
        chk("same1_retire_gnt", 32'(retire_gnt_o), 32'd1);
        chk("same1_retire_err", 32'(retire_err_o), 32'd0);
        step();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
        chk("same1_query4", 32'(query_cnt_o), 32'd1);
        chk("same1_empty", 32'(empty_o), 32'd0);

        // ID 4 at cnt=3: issue denied, retire still applies
        drive(1'b1, 4'd4, 1'b0, 4'd0, 4'd4);
        step();
        step();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
        chk("sat_query4", 32'(query_cnt_o), 32'd3);
        drive(1'b1, 4'd4, 1'b1, 4'd4, 4'd4);
        chk("sat_issue_gnt", 32'(issue_gnt_o), 32'd0);
        step();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 4'd4);
        chk("sat_query4_after", 32'(query_cnt_o), 32'd2);

        // second ID, then async reset pulse between edges
        drive(1'b1, 4'd8, 1'b0, 4'd0, 4'd8);
        step();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 4'd8);
        chk("pre_rst_query8", 32'(query_cnt_o), 32'd1);
        chk("pre_rst_full", 32'(full_o), 32'd1);
        rst_ni = 1'b0;
        #1;
        chk("async_empty", 32'(empty_o), 32'd1);
        chk("async_full", 32'(full_o), 32'd0);
        chk("async_query8", 32'(query_cnt_o), 32'd0);
        query_id_i = 4'd4;
        #1;
        chk("async_query4", 32'(query_cnt_o), 32'd0);
        rst_ni = 1'b1;
        step();
        chk("post_rst_empty", 32'(empty_o), 32'd1);
        drive(1'b1, 4'd9, 1'b0, 4'd0, 4'd9);
        chk("post_rst_gnt", 32'(issue_gnt_o), 32'd1);
        step();
        drive(1'b0, 4'd0, 1'b0, 4'd0, 4'd9);
        chk("post_rst_query9", 32'(query_cnt_o), 32'd1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
